fix_frame_extractor: RTL and testbench

- Upstream framing stage of the FIX parser. Sits between the raw byte receiver and the checksum generator.
- Hunts for a message header "8=" and streams every checksummed byte downstream, from '8' through the SOH (8'h01) that precedes the trailer.
- Marks the frame with start/end qualifiers. Strips the "10=ddd<SOH>" trailer and presents the received checksum in ASCII and binary form for the downstream comparator.

---
 rtl/fix_frame_extractor_if.sv | 29 ++
 rtl/fix_frame_extractor.sv | 163 ++++++++++++++++
 tb/tb_fix_frame_extractor.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fix_frame_extractor_if.sv
// Byte-stream handshake between the raw receiver, the frame extractor and the
// checksum stage: one received byte in, one framed body beat plus trailer status out.
interface fix_frame_extractor_if;
  logic [7:0]  data_i;
  logic        data_valid_i;
  logic [7:0]  data_o;
  logic        data_valid_o;
  logic        start_o;
  logic        end_o;
  logic [23:0] rx_checksum_o;
  logic [9:0]  rx_checksum_bin_o;
  logic        rx_checksum_valid_o;
  logic        frame_error_o;
  logic        abort_o;

  modport master (
    output data_i, data_valid_i,
    input  data_o, data_valid_o, start_o, end_o,
    input  rx_checksum_o, rx_checksum_bin_o, rx_checksum_valid_o,
    input  frame_error_o, abort_o
  );

  modport slave (
    input  data_i, data_valid_i,
    output data_o, data_valid_o, start_o, end_o,
    output rx_checksum_o, rx_checksum_bin_o, rx_checksum_valid_o,
    output frame_error_o, abort_o
  );
endinterface

// File: rtl/fix_frame_extractor.sv
// FIX framing stage: finds "8=", streams checksummed body bytes through a
// 2-deep delay line, strips the "10=ddd<SOH>" trailer and reports its value.
module fix_frame_extractor #(
  parameter int MAX_LEN = 4096,
  parameter int CNT_W   = 13
) (
  input logic                 clk,
  input logic                 rst,
  fix_frame_extractor_if.slave bus
);
  typedef enum logic [2:0] {IDLE, HDR, BODY, DIG, TERM} state_t;

  localparam logic [7:0] SOH    = 8'h01;
  localparam logic [7:0] ASC_8  = 8'h38;
  localparam logic [7:0] ASC_EQ = 8'h3D;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_1  = 8'h31;
  localparam logic [7:0] ASC_9  = 8'h39;

  state_t           state_q, state_d;
  logic [7:0]       sr1_q, sr0_q;
  logic             last_soh_q, first_q;
  logic [CNT_W-1:0] len_q;
  logic [1:0]       dcnt_q;
  logic [23:0]      ck_q;
  logic [9:0]       bin_q;

  logic             is_digit, trailer_hit, len_full;
  logic [7:0]       data_d;
  logic             dv_d, start_d, end_d, ckv_d, ferr_d, abort_d;

  assign is_digit    = (bus.data_i >= ASC_0) && (bus.data_i <= ASC_9);
  // "10=" only counts as the trailer when the byte before the '1' was an emitted SOH
  assign trailer_hit = (state_q == BODY) && (bus.data_i == ASC_EQ) &&
                       (sr0_q == ASC_0) && (sr1_q == ASC_1) && last_soh_q;
  assign len_full    = (len_q == CNT_W'(MAX_LEN));

  assign bus.rx_checksum_o     = ck_q;
  assign bus.rx_checksum_bin_o = bin_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.data_valid_i) begin
      case (state_q)
        IDLE: if (bus.data_i == ASC_8) state_d = HDR;
        HDR: begin
          if (bus.data_i == ASC_EQ)     state_d = BODY;
          else if (bus.data_i != ASC_8) state_d = IDLE;
        end
        BODY: begin
          if (trailer_hit)   state_d = DIG;
          else if (len_full) state_d = IDLE;
        end
        DIG: begin
          if (!is_digit)            state_d = IDLE;
          else if (dcnt_q == 2'd2)  state_d = TERM;
        end
        TERM:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d  = '0;
    dv_d    = 1'b0;
    start_d = 1'b0;
    end_d   = 1'b0;
    ckv_d   = 1'b0;
    ferr_d  = 1'b0;
    abort_d = 1'b0;
    if (bus.data_valid_i) begin
      case (state_q)
        BODY: begin
          if (trailer_hit) begin
            dv_d  = 1'b1;
            end_d = 1'b1;
          end else if (len_full) begin
            abort_d = 1'b1;
          end else begin
            dv_d    = 1'b1;
            data_d  = sr1_q;
            start_d = first_q;
          end
        end
        DIG:     ferr_d = !is_digit;
        TERM: begin
          ckv_d  = (bus.data_i == SOH);
          ferr_d = (bus.data_i != SOH);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.data_o              <= '0;
      bus.data_valid_o        <= 1'b0;
      bus.start_o             <= 1'b0;
      bus.end_o               <= 1'b0;
      bus.rx_checksum_valid_o <= 1'b0;
      bus.frame_error_o       <= 1'b0;
      bus.abort_o             <= 1'b0;
      sr1_q      <= '0;
      sr0_q      <= '0;
      last_soh_q <= 1'b0;
      first_q    <= 1'b0;
      len_q      <= '0;
      dcnt_q     <= '0;
      ck_q       <= '0;
      bin_q      <= '0;
    end else begin
      bus.data_o              <= data_d;
      bus.data_valid_o        <= dv_d;
      bus.start_o             <= start_d;
      bus.end_o               <= end_d;
      bus.rx_checksum_valid_o <= ckv_d;
      bus.frame_error_o       <= ferr_d;
      bus.abort_o             <= abort_d;
      if (bus.data_valid_i) begin
        case (state_q)
          HDR: if (bus.data_i == ASC_EQ) begin
            sr1_q      <= ASC_8;
            sr0_q      <= ASC_EQ;
            len_q      <= '0;
            last_soh_q <= 1'b0;
            first_q    <= 1'b1;
          end
          BODY: begin
            if (trailer_hit) begin
              sr1_q  <= '0;
              sr0_q  <= '0;
              dcnt_q <= '0;
              ck_q   <= '0;
              bin_q  <= '0;
            end else if (len_full) begin
              sr1_q <= '0;
              sr0_q <= '0;
            end else begin
              sr1_q      <= sr0_q;
              sr0_q      <= bus.data_i;
              len_q      <= len_q + 1'b1;
              last_soh_q <= (sr1_q == SOH);
              first_q    <= 1'b0;
            end
          end
          DIG: if (is_digit) begin
            ck_q   <= {ck_q[15:0], bus.data_i};
            bin_q  <= bin_q * 10'd10 + {6'd0, bus.data_i[3:0]};
            dcnt_q <= dcnt_q + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fix_frame_extractor.sv
// Scoreboard bench: two extractors (default and MAX_LEN=8) share one byte stream;
// a stream-level reference model predicts each one's output events.
module tb_fix_frame_extractor;
  typedef logic [7:0] bq_t[$];
  typedef enum int {K_BEAT, K_END, K_CKV, K_FERR, K_ABORT} kind_t;
  typedef struct {
    kind_t       kind;
    logic [7:0]  data;
    logic        start;
    logic [23:0] ck;
    logic [9:0]  bin;
  } ev_t;
  typedef ev_t eq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vin_q = 1'b0;
  always #5 clk = ~clk;

  fix_frame_extractor_if bif_a ();
  fix_frame_extractor_if bif_b ();

  fix_frame_extractor #(.MAX_LEN(4096), .CNT_W(13)) dut_a (.clk(clk), .rst(rst), .bus(bif_a));
  fix_frame_extractor #(.MAX_LEN(8),    .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bif_b));

  logic        mdv[2], mst[2], mend[2], mckv[2], mfe[2], mab[2];
  logic [7:0]  mdat[2];
  logic [23:0] mck[2];
  logic [9:0]  mbin[2];
  assign mdv[0]  = bif_a.data_valid_o;         assign mdv[1]  = bif_b.data_valid_o;
  assign mst[0]  = bif_a.start_o;              assign mst[1]  = bif_b.start_o;
  assign mend[0] = bif_a.end_o;                assign mend[1] = bif_b.end_o;
  assign mckv[0] = bif_a.rx_checksum_valid_o;  assign mckv[1] = bif_b.rx_checksum_valid_o;
  assign mfe[0]  = bif_a.frame_error_o;        assign mfe[1]  = bif_b.frame_error_o;
  assign mab[0]  = bif_a.abort_o;              assign mab[1]  = bif_b.abort_o;
  assign mdat[0] = bif_a.data_o;               assign mdat[1] = bif_b.data_o;
  assign mck[0]  = bif_a.rx_checksum_o;        assign mck[1]  = bif_b.rx_checksum_o;
  assign mbin[0] = bif_a.rx_checksum_bin_o;    assign mbin[1] = bif_b.rx_checksum_bin_o;

  always @(posedge clk) vin_q <= bif_a.data_valid_i;

  int   checks = 0;
  int   errors = 0;
  bq_t  hist;
  int   npushed[2];
  ev_t  expq[2][$];

  function automatic ev_t mk(kind_t k, logic [7:0] d, logic s, logic [23:0] c, logic [9:0] b);
    ev_t e;
    e.kind = k; e.data = d; e.start = s; e.ck = c; e.bin = b;
    return e;
  endfunction

  function automatic bit is_dig(logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  // Whole-stream model: frames start at the first "8=", body is everything up to
  // and including the SOH in front of "10=", at most maxlen beats; a byte is seen
  // on the output only once two later bytes have arrived.
  function automatic void model(input bq_t s, input int maxlen, output eq_t ev);
    int n, p, q, t, i, val;
    logic [23:0] ck;
    ev = {};
    n = s.size();
    p = 0;
    while (p < n) begin
      if (s[p] != 8'h38 || p + 1 >= n || s[p+1] != 8'h3D) begin
        p++;
        continue;
      end
      i = p;
      q = i + 2;
      p = n;
      while (q < n) begin
        if (q - 3 >= i && s[q] == 8'h3D && s[q-1] == 8'h30 && s[q-2] == 8'h31 && s[q-3] == 8'h01) begin
          ev.push_back(mk(K_END, 8'h00, 1'b0, '0, '0));
          ck = '0; val = 0; t = q + 1;
          while (t < n && t <= q + 3 && is_dig(s[t])) begin
            ck  = {ck[15:0], s[t]};
            val = val * 10 + int'(s[t]) - 48;
            t++;
          end
          if (t < n) begin
            if (t <= q + 3)         ev.push_back(mk(K_FERR, '0, 1'b0, '0, '0));
            else if (s[t] == 8'h01) ev.push_back(mk(K_CKV, '0, 1'b0, ck, 10'(val)));
            else                    ev.push_back(mk(K_FERR, '0, 1'b0, '0, '0));
            p = t + 1;
          end
          break;
        end
        if (q - 2 - i == maxlen) begin
          ev.push_back(mk(K_ABORT, '0, 1'b0, '0, '0));
          p = q + 1;
          break;
        end
        ev.push_back(mk(K_BEAT, s[q-2], q == i + 2, '0, '0));
        q++;
      end
    end
  endfunction

  function automatic bq_t str2q(string s);
    bq_t q;
    q = {};
    for (int i = 0; i < s.len(); i++) q.push_back(s[i] == 8'h7C ? 8'h01 : s[i]);
    return q;
  endfunction

  function automatic bq_t rand_frame();
    bq_t s;
    string t;
    int ng, nf, vl, bad, r;
    logic [7:0] dg[3];
    s = {};
    ng = int'($urandom_range(0, 3));
    for (int k = 0; k < ng; k++) s.push_back(8'(65 + $urandom_range(0, 25)));
    s.push_back(8'h38); s.push_back(8'h3D);
    nf = int'($urandom_range(0, 3));
    for (int f = 0; f < nf; f++) begin
      t = $sformatf("%0d", $urandom_range(11, 999));
      for (int i = 0; i < t.len(); i++) s.push_back(t[i]);
      s.push_back(8'h3D);
      vl = int'($urandom_range(1, 5));
      for (int i = 0; i < vl; i++) begin
        r = int'($urandom_range(0, 35));
        s.push_back(r < 26 ? 8'(65 + r) : 8'(48 + r - 26));
      end
      s.push_back(8'h01);
    end
    s.push_back(8'h31); s.push_back(8'h30); s.push_back(8'h3D);
    for (int i = 0; i < 3; i++) dg[i] = 8'(48 + $urandom_range(0, 9));
    bad = int'($urandom_range(0, 5));
    if (bad == 0) dg[$urandom_range(0, 2)] = 8'h58;
    for (int i = 0; i < 3; i++) s.push_back(dg[i]);
    s.push_back(bad == 1 ? 8'h5A : 8'h01);
    return s;
  endfunction

  task automatic drive(input logic v, input logic [7:0] b);
    bif_a.data_valid_i = v; bif_a.data_i = b;
    bif_b.data_valid_i = v; bif_b.data_i = b;
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    eq_t ev;
    for (int d = 0; d < 2; d++) begin
      model(hist, d == 0 ? 4096 : 8, ev);
      for (int k = npushed[d]; k < ev.size(); k++) expq[d].push_back(ev[k]);
      npushed[d] = ev.size();
    end
  endtask

  // mode 0: back-to-back, 1: alternate valid/idle, 2: random idle gaps
  task automatic send(input bq_t s, input int mode);
    foreach (s[k]) hist.push_back(s[k]);
    push_expected();
    foreach (s[k]) begin
      if (mode == 2) repeat ($urandom_range(0, 2)) drive(1'b0, 8'($urandom));
      drive(1'b1, s[k]);
      if (mode == 1) drive(1'b0, 8'($urandom));
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((expq[0].size() != 0 || expq[1].size() != 0) && w < 100) begin
      @(posedge clk);
      w++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (expq[0].size() != 0 || expq[1].size() != 0) begin
      errors++;
      $display("FAIL drain_%s: pending events a=%0d b=%0d, required 0 0", name, expq[0].size(), expq[1].size());
      expq[0] = {};
      expq[1] = {};
    end
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({mdv[d], mst[d], mend[d], mckv[d], mfe[d], mab[d], mdat[d], mck[d], mbin[d]} != '0) begin
        errors++;
        $display("FAIL %s_dut%0d: outputs dv=%0b st=%0b end=%0b ckv=%0b fe=%0b ab=%0b data=%02h ck=%06h bin=%0d, required all 0",
                 name, d, mdv[d], mst[d], mend[d], mckv[d], mfe[d], mab[d], mdat[d], mck[d], mbin[d]);
      end
    end
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    check_zero(name);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist = {};
    npushed[0] = 0;
    npushed[1] = 0;
    expq[0] = {};
    expq[1] = {};
  endtask

  task automatic check_ck(input string name, input logic [23:0] ck, input logic [9:0] bin);
    checks++;
    if (bif_a.rx_checksum_o != ck || bif_a.rx_checksum_bin_o != bin) begin
      errors++;
      $display("FAIL %s: rx_checksum=%06h bin=%0d, required %06h %0d", name,
               bif_a.rx_checksum_o, bif_a.rx_checksum_bin_o, ck, bin);
    end
  endtask

  task automatic monitor();
    eq_t got;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          got = {};
          if (!vin_q) begin
            checks++;
            if (mdv[d] | mckv[d] | mfe[d] | mab[d]) begin
              errors++;
              $display("FAIL gap_dut%0d: dv=%0b ckv=%0b fe=%0b ab=%0b after idle input, required 0",
                       d, mdv[d], mckv[d], mfe[d], mab[d]);
            end
          end
          if (mdv[d])  got.push_back(mk(mend[d] ? K_END : K_BEAT, mdat[d], mst[d], '0, '0));
          if (mckv[d]) got.push_back(mk(K_CKV, '0, 1'b0, mck[d], mbin[d]));
          if (mfe[d])  got.push_back(mk(K_FERR, '0, 1'b0, '0, '0));
          if (mab[d])  got.push_back(mk(K_ABORT, '0, 1'b0, '0, '0));
          foreach (got[g]) begin
            checks++;
            if (expq[d].size() == 0) begin
              errors++;
              $display("FAIL unexpected_dut%0d: got kind=%0d data=%02h start=%0b, required no event",
                       d, got[g].kind, got[g].data, got[g].start);
            end else begin
              e = expq[d].pop_front();
              if (e.kind != got[g].kind || e.data != got[g].data || e.start != got[g].start ||
                  e.ck != got[g].ck || e.bin != got[g].bin) begin
                errors++;
                $display("FAIL event_dut%0d: got kind=%0d data=%02h start=%0b ck=%06h bin=%0d, required kind=%0d data=%02h start=%0b ck=%06h bin=%0d",
                         d, got[g].kind, got[g].data, got[g].start, got[g].ck, got[g].bin,
                         e.kind, e.data, e.start, e.ck, e.bin);
              end
            end
          end
        end
      end
    end
  endtask

  initial begin
    bq_t s;
    bif_a.data_valid_i = 1'b0; bif_a.data_i = 8'h00;
    bif_b.data_valid_i = 1'b0; bif_b.data_i = 8'h00;
    hist = {};
    npushed[0] = 0;
    npushed[1] = 0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    send(str2q("8=FIX.4.2|9=5|35=0|10=123|"), 0);
    drain("main");
    check_ck("main_ck", 24'h313233, 10'd123);

    send(str2q("8=FIX.4.2|9=5|35=0|10=123|"), 1);
    drain("toggle");
    check_ck("toggle_ck", 24'h313233, 10'd123);

    send(str2q("8=FIX.4.2|110=7|10=045|"), 2);
    drain("tag110");
    check_ck("tag110_ck", 24'h303435, 10'd45);

    send(str2q("8=A|10=1A3|8=B|10=999|"), 0);
    drain("bad_digit");
    check_ck("bad_digit_ck", 24'h393939, 10'd999);

    do_reset("pre_abort");
    s = str2q("8=");
    repeat (18) s.push_back(8'(65 + $urandom_range(0, 25)));
    send(s, 0);
    drain("abort");

    do_reset("pre_mid");
    send(str2q("8=FIX.4"), 0);
    drain("prefix");
    do_reset("mid_body");
    send(str2q("8=FIX.4.2|9=5|35=0|10=123|"), 2);
    drain("after_reset");
    check_ck("after_reset_ck", 24'h313233, 10'd123);

    for (int r = 0; r < 40; r++) begin
      if (r % 8 == 0) do_reset("random");
      send(rand_frame(), int'($urandom_range(0, 2)));
    end
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
